// File: rtl/ss_seq_ctrl.sv
// Save-state sequencer: walks slots 0..REG_LAST then IDX_ADDR, one byte each.
// Define SS_SEQ_CSUM_EN to append/consume an 8-bit two's-complement checksum byte.
module ss_seq_ctrl #(
    parameter int REG_LAST = 17,
    parameter int IDX_ADDR = 127,
    parameter int ACC_CYC  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_start,
    input  logic       cmd_load,
    input  logic       cmd_abort,
    output logic       cmd_busy,
    output logic       cmd_done,
    output logic       cmd_err,
    output logic       ss_req,
    input  logic       ss_gnt,
    output logic       ss_act,
    output logic       ss_we,
    output logic [7:0] ss_addr,
    output logic [7:0] ss_wdat,
    input  logic [7:0] ss_rdat,
    output logic [7:0] so_data,
    output logic       so_valid,
    input  logic       so_ready,
    input  logic [7:0] si_data,
    input  logic       si_valid,
    output logic       si_ready
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_REQ,
        S_SETUP,
        S_FETCH,
        S_ACCESS,
        S_EMIT,
        S_CHECK,
        S_NEXT,
        S_CSUM,
        S_DONE
    } state_e;

    localparam logic [7:0] LAST_A  = 8'(REG_LAST);
    localparam logic [7:0] IDX_A   = 8'(IDX_ADDR);
    localparam logic [3:0] CNT_END = 4'(ACC_CYC - 1);
    localparam logic [3:0] WE_END  = 4'(ACC_CYC - 2);

    state_e     state_q, state_d;
    logic       load_q, load_d;
    logic       err_q, err_d;
    logic       have_q, have_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdat_q, wdat_d;
    logic [7:0] rdat_q, rdat_d;
    logic [7:0] sum_q, sum_d;
    logic [3:0] cnt_q, cnt_d;

    logic is_idx;
    logic acc_last;
    logic on_bus;

    assign is_idx   = (addr_q == IDX_A);
    assign acc_last = (cnt_q == CNT_END);
    assign on_bus   = state_q inside {S_SETUP, S_FETCH, S_ACCESS,
                                      S_EMIT, S_CHECK};

    assign cmd_busy = (state_q != S_IDLE) && (state_q != S_DONE);
    assign ss_req   = cmd_busy;
    assign cmd_done = (state_q == S_DONE);
    assign cmd_err  = err_q;
    assign ss_addr  = addr_q;
    assign ss_wdat  = wdat_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            load_q  <= 1'b0;
            err_q   <= 1'b0;
            have_q  <= 1'b0;
            addr_q  <= 8'h00;
            wdat_q  <= 8'h00;
            rdat_q  <= 8'h00;
            sum_q   <= 8'h00;
            cnt_q   <= 4'h0;
        end else begin
            state_q <= state_d;
            load_q  <= load_d;
            err_q   <= err_d;
            have_q  <= have_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
        end
    end

    // Bus strobes are gated by ss_gnt so a lost grant releases the bus at once.
    always_comb begin
        state_d  = state_q;
        load_d   = load_q;
        err_d    = err_q;
        have_d   = have_q;
        addr_d   = addr_q;
        wdat_d   = wdat_q;
        rdat_d   = rdat_q;
        sum_d    = sum_q;
        cnt_d    = cnt_q;
        ss_act   = 1'b0;
        ss_we    = 1'b0;
        so_data  = 8'h00;
        so_valid = 1'b0;
        si_ready = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_start) begin
                    load_d  = cmd_load;
                    err_d   = 1'b0;
                    have_d  = 1'b0;
                    addr_d  = 8'h00;
                    sum_d   = 8'h00;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (ss_gnt) begin
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                ss_act = ss_gnt;
                cnt_d  = 4'h0;
                if (load_q && !is_idx && !have_q) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_ACCESS;
                end
            end
            S_FETCH: begin
                ss_act   = ss_gnt;
                si_ready = ss_gnt;
                if (si_valid && ss_gnt) begin
                    wdat_d  = si_data;
                    have_d  = 1'b1;
                    sum_d   = sum_q + si_data;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                ss_act = ss_gnt;
                ss_we  = ss_gnt && load_q && !is_idx &&
                         (cnt_q != 4'h0) && (cnt_q <= WE_END);
                if (acc_last) begin
                    rdat_d = ss_rdat;
                    if (!load_q) begin
                        state_d = S_EMIT;
                    end else if (is_idx) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_NEXT;
                    end
                end else begin
                    cnt_d = cnt_q + 4'h1;
                end
            end
            S_EMIT: begin
                ss_act   = ss_gnt;
                so_valid = ss_gnt;
                so_data  = rdat_q;
                if (so_ready && ss_gnt) begin
                    sum_d   = sum_q + rdat_q;
                    state_d = S_NEXT;
                end
            end
            S_CHECK: begin
                ss_act   = ss_gnt;
                si_ready = ss_gnt;
                if (si_valid && ss_gnt) begin
                    if (si_data != rdat_q) begin
                        err_d = 1'b1;
                    end
                    sum_d   = sum_q + si_data;
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                have_d = 1'b0;
                if (is_idx) begin
`ifdef SS_SEQ_CSUM_EN
                    state_d = S_CSUM;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    addr_d  = (addr_q == LAST_A) ? IDX_A
                                                 : addr_q + 8'h01;
                    state_d = S_SETUP;
                end
            end
`ifdef SS_SEQ_CSUM_EN
            S_CSUM: begin
                if (!load_q) begin
                    so_valid = 1'b1;
                    so_data  = 8'h00 - sum_q;
                    if (so_ready) begin
                        state_d = S_DONE;
                    end
                end else begin
                    si_ready = 1'b1;
                    if (si_valid) begin
                        if ((sum_q + si_data) != 8'h00) begin
                            err_d = 1'b1;
                        end
                        state_d = S_DONE;
                    end
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Current slot restarts from SETUP once the arbiter re-grants.
        if (on_bus && !ss_gnt) begin
            state_d = S_REQ;
        end

        if (cmd_abort && (state_q != S_IDLE) && (state_q != S_DONE)) begin
            err_d   = 1'b1;
            state_d = S_DONE;
        end
    end

endmodule

// File: tb/tb_ss_seq_ctrl.sv
// Scoreboard bench for ss_seq_ctrl: arbiter, mapper and stream models at negedge.
// Build with SS_SEQ_CSUM_EN defined on both files to cover the checksum byte.
module tb_ss_seq_ctrl;
    localparam int ACC = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_start, cmd_load, cmd_abort;
    logic       cmd_busy, cmd_done, cmd_err;
    logic       ss_req, ss_gnt, ss_act, ss_we;
    logic [7:0] ss_addr, ss_wdat, ss_rdat;
    logic [7:0] so_data, si_data;
    logic       so_valid, so_ready, si_valid, si_ready;

    int checks = 0;
    int errors = 0;

    logic       xor_mode;
    logic [7:0] mem [256];

    logic [7:0] src [$];
    int         src_idx;
    bit         si_pend;
    logic [7:0] got_q [$];
    logic [7:0] exp_q [$];
    logic [7:0] wr_a [$];
    logic [7:0] wr_d [$];
    int         wr_l [$];
    int         wr_bad, we_cyc, act_cyc, run_len;
    logic [7:0] run_a, run_d;
    bit         prev_we, prev_act;
    int         setups [256];
    int         act_run, req_cnt, drop_left, stall_left;
    bit         drop_en, dropped, stall_en, stall_seen;
    logic [7:0] drop_addr, stall_addr;

    always #5 clk = ~clk;

    assign ss_rdat = xor_mode ? (ss_addr ^ 8'h5A) : mem[ss_addr];

    ss_seq_ctrl dut (
        .clk(clk), .rst(rst),
        .cmd_start(cmd_start), .cmd_load(cmd_load), .cmd_abort(cmd_abort),
        .cmd_busy(cmd_busy), .cmd_done(cmd_done), .cmd_err(cmd_err),
        .ss_req(ss_req), .ss_gnt(ss_gnt), .ss_act(ss_act), .ss_we(ss_we),
        .ss_addr(ss_addr), .ss_wdat(ss_wdat), .ss_rdat(ss_rdat),
        .so_data(so_data), .so_valid(so_valid), .so_ready(so_ready),
        .si_data(si_data), .si_valid(si_valid), .si_ready(si_ready)
    );

    // Environment: drive inputs at negedge, observe the settled cycle 1 later.
    always begin
        @(negedge clk);
        if (si_pend) src_idx++;
        si_pend = 1'b0;
        if (drop_en && !dropped && ss_act && ss_addr == drop_addr && act_run == 3) begin
            dropped   = 1'b1;
            drop_left = 4;
        end
        if (drop_left > 0) begin
            ss_gnt = 1'b0;
            drop_left--;
            req_cnt = 0;
        end else if (ss_req) begin
            if (req_cnt >= 3) ss_gnt = 1'b1;
            else req_cnt++;
        end else begin
            ss_gnt  = 1'b0;
            req_cnt = 0;
        end
        if (stall_en && !stall_seen && so_valid && ss_addr == stall_addr) begin
            stall_seen = 1'b1;
            stall_left = 5;
        end
        if (stall_left > 0) begin
            so_ready = 1'b0;
            stall_left--;
        end else begin
            so_ready = 1'b1;
        end
        si_valid = (src_idx < src.size());
        si_data  = si_valid ? src[src_idx] : 8'h00;
        #1;
        if (ss_we) begin
            we_cyc++;
            if (!prev_we) begin
                run_a   = ss_addr;
                run_d   = ss_wdat;
                run_len = 0;
            end else if (ss_addr != run_a || ss_wdat != run_d) begin
                wr_bad++;
            end
            run_len++;
            mem[ss_addr] = ss_wdat;
        end else if (prev_we) begin
            wr_a.push_back(run_a);
            wr_d.push_back(run_d);
            wr_l.push_back(run_len);
        end
        prev_we = ss_we;
        if (ss_act) begin
            act_cyc++;
            act_run++;
            if (!prev_act) setups[ss_addr]++;
        end else begin
            act_run = 0;
        end
        prev_act = ss_act;
        if (so_valid && so_ready) got_q.push_back(so_data);
        if (si_valid && si_ready) si_pend = 1'b1;
    end

    task automatic clr_env();
        src.delete();
        got_q.delete();
        exp_q.delete();
        wr_a.delete();
        wr_d.delete();
        wr_l.delete();
        src_idx = 0; si_pend = 1'b0;
        wr_bad = 0; we_cyc = 0; act_cyc = 0; run_len = 0;
        prev_we = 1'b0; prev_act = 1'b0;
        act_run = 0; req_cnt = 0; drop_left = 0; stall_left = 0;
        drop_en = 1'b0; dropped = 1'b0; stall_en = 1'b0; stall_seen = 1'b0;
        drop_addr = 8'h00; stall_addr = 8'h00;
        foreach (setups[i]) setups[i] = 0;
    endtask

    task automatic start_op(input logic ld);
        @(negedge clk); #2;
        cmd_load  = ld;
        cmd_start = 1'b1;
        @(negedge clk); #2;
        cmd_start = 1'b0;
    endtask

    task automatic wait_done(output bit seen, output logic err, output logic busy);
        seen = 1'b0; err = 1'b0; busy = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk); #2;
            if (cmd_done) begin
                seen = 1'b1;
                err  = cmd_err;
                busy = cmd_busy;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL done_timeout: cmd_done=0 after 3000 cycles, want 1");
        end
    endtask

    task automatic build_save_exp();
        for (int a = 0; a <= 17; a++) exp_q.push_back(8'(a) ^ 8'h5A);
        exp_q.push_back(8'h25);
`ifdef SS_SEQ_CSUM_EN
        begin
            logic [7:0] s;
            s = 8'h00;
            foreach (exp_q[i]) s += exp_q[i];
            exp_q.push_back(8'h00 - s);
        end
`endif
    endtask

    task automatic build_load_src(input logic [7:0] idx_b);
        for (int a = 0; a <= 17; a++) src.push_back(8'(a));
        src.push_back(idx_b);
`ifdef SS_SEQ_CSUM_EN
        begin
            logic [7:0] s;
            s = 8'h00;
            foreach (src[i]) s += src[i];
            src.push_back(8'h00 - s);
        end
`endif
    endtask

    task automatic test_reset();
        logic [43:0] outs;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        outs = {cmd_busy, cmd_done, cmd_err, ss_req, ss_act, ss_we,
                ss_addr, ss_wdat, so_data, so_valid, si_ready, 14'h0, so_data};
        checks++;
        if (outs !== 44'h0) begin
            errors++;
            $display("FAIL reset_outs: got %h want 0", outs);
        end
        rst = 1'b0;
    endtask

    task automatic test_save();
        bit seen; logic err, busy; logic [7:0] g, e;
        clr_env();
        xor_mode = 1'b1;
        build_save_exp();
        start_op(1'b0);
        checks++;
        if (cmd_busy !== 1'b1 || ss_req !== 1'b1) begin
            errors++;
            $display("FAIL save_busy: busy=%b req=%b want 1 1", cmd_busy, ss_req);
        end
        wait_done(seen, err, busy);
        checks++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL save_done: err=%b busy=%b want 0 0", err, busy);
        end
        checks++;
        if (we_cyc != 0) begin
            errors++;
            $display("FAIL save_we: %0d write cycles, want 0", we_cyc);
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL save_len: got %0d bytes want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL save_byte%0d: got %h want %h", i, g, e);
            end
        end
    endtask

    task automatic test_load(input logic [7:0] idx_b, input logic want_err);
        bit seen; logic err, busy; int n127;
        clr_env();
        xor_mode = 1'b0;
        mem[127] = 8'h7F;
        build_load_src(idx_b);
        start_op(1'b1);
        wait_done(seen, err, busy);
        checks++;
        if (err !== want_err) begin
            errors++;
            $display("FAIL load_err_idx%h: cmd_err=%b want %b", idx_b, err, want_err);
        end
        checks++;
        if (wr_a.size() != 18 || we_cyc != 18 * (ACC - 2) || wr_bad != 0) begin
            errors++;
            $display("FAIL load_wcount: runs=%0d cyc=%0d unstable=%0d want 18 %0d 0",
                     wr_a.size(), we_cyc, wr_bad, 18 * (ACC - 2));
        end
        for (int i = 0; i < 18; i++) begin
            checks++;
            if (i >= wr_a.size()) begin
                errors++;
                $display("FAIL load_wr%0d: missing, want addr %h", i, 8'(i));
            end else if (wr_a[i] !== 8'(i) || wr_d[i] !== 8'(i) || wr_l[i] != ACC - 2) begin
                errors++;
                $display("FAIL load_wr%0d: a=%h d=%h len=%0d want %h %h %0d",
                         i, wr_a[i], wr_d[i], wr_l[i], 8'(i), 8'(i), ACC - 2);
            end
        end
        n127 = 0;
        foreach (wr_a[i]) if (wr_a[i] == 8'd127) n127++;
        checks++;
        if (n127 != 0 || src_idx != src.size()) begin
            errors++;
            $display("FAIL load_idx: writes127=%0d consumed=%0d want 0 %0d",
                     n127, src_idx, src.size());
        end
    endtask

    task automatic test_save_stall();
        bit seen; logic err, busy; logic [7:0] g, e;
        clr_env();
        xor_mode   = 1'b1;
        stall_en   = 1'b1;
        stall_addr = 8'd9;
        drop_en    = 1'b1;
        drop_addr  = 8'd12;
        build_save_exp();
        start_op(1'b0);
        wait_done(seen, err, busy);
        checks++;
        if (!stall_seen || !dropped || setups[12] != 2 || setups[11] != 1) begin
            errors++;
            $display("FAIL stall_retry: stall=%b drop=%b setups12=%0d setups11=%0d want 1 1 2 1",
                     stall_seen, dropped, setups[12], setups[11]);
        end
        checks++;
        if (err !== 1'b0 || got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL stall_len: err=%b bytes=%0d want 0 %0d", err, got_q.size(), exp_q.size());
        end
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL stall_byte%0d: got %h want %h", i, g, e);
            end
        end
    endtask

    task automatic test_abort();
        bit seen, hit; logic err, busy;
        clr_env();
        xor_mode = 1'b0;
        mem[127] = 8'h7F;
        build_load_src(8'h7F);
        start_op(1'b1);
        hit = 1'b0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            @(negedge clk); #2;
            if (ss_we && ss_addr == 8'd4) hit = 1'b1;
        end
        cmd_abort = 1'b1;
        @(negedge clk); #2;
        cmd_abort = 1'b0;
        checks++;
        if (!hit || ss_we !== 1'b0 || ss_act !== 1'b0 || so_valid !== 1'b0 ||
            si_ready !== 1'b0 || cmd_done !== 1'b1 || cmd_err !== 1'b1) begin
            errors++;
            $display("FAIL abort_now: hit=%b we=%b act=%b sov=%b sir=%b done=%b err=%b want 1 0 0 0 0 1 1",
                     hit, ss_we, ss_act, so_valid, si_ready, cmd_done, cmd_err);
        end
        act_cyc = 0;
        repeat (20) @(negedge clk);
        #2;
        checks++;
        if (act_cyc != 0 || wr_a.size() != 5) begin
            errors++;
            $display("FAIL abort_after: act_cycles=%0d runs=%0d want 0 5", act_cyc, wr_a.size());
        end
        clr_env();
        build_load_src(8'h7F);
        start_op(1'b1);
        wait_done(seen, err, busy);
        checks++;
        if (err !== 1'b0 || wr_a.size() != 18) begin
            errors++;
            $display("FAIL abort_rerun: err=%b runs=%0d want 0 18", err, wr_a.size());
        end
    endtask

    task automatic test_async_reset();
        bit hit;
        clr_env();
        xor_mode = 1'b0;
        build_load_src(8'h7F);
        start_op(1'b1);
        hit = 1'b0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            @(negedge clk); #2;
            if (ss_we) hit = 1'b1;
        end
        rst = 1'b1;
        #1;
        checks++;
        if (!hit || ss_we !== 1'b0 || ss_act !== 1'b0 || ss_req !== 1'b0 || cmd_busy !== 1'b0) begin
            errors++;
            $display("FAIL async_rst: hit=%b we=%b act=%b req=%b busy=%b want 1 0 0 0 0",
                     hit, ss_we, ss_act, ss_req, cmd_busy);
        end
        @(negedge clk); #2;
        rst = 1'b0;
    endtask

`ifdef SS_SEQ_CSUM_EN
    task automatic test_csum();
        bit seen; logic err, busy; logic [7:0] saved [$]; logic [7:0] s, e;
        clr_env();
        xor_mode = 1'b1;
        build_save_exp();
        e = exp_q[exp_q.size() - 1];
        start_op(1'b0);
        wait_done(seen, err, busy);
        saved = got_q;
        s = 8'h00;
        foreach (saved[i]) s += saved[i];
        checks++;
        if (saved.size() != 20 || saved[saved.size() - 1] !== e || s !== 8'h00) begin
            errors++;
            $display("FAIL csum_save: bytes=%0d last=%h total=%h want 20 %h 00",
                     saved.size(), saved[saved.size() - 1], s, e);
        end
        clr_env();
        xor_mode = 1'b0;
        mem[127] = 8'h25;
        src = saved;
        start_op(1'b1);
        wait_done(seen, err, busy);
        checks++;
        if (err !== 1'b0 || src_idx != 20) begin
            errors++;
            $display("FAIL csum_load: err=%b consumed=%0d want 0 20", err, src_idx);
        end
        clr_env();
        src = saved;
        src[5] = src[5] + 8'h01;
        start_op(1'b1);
        wait_done(seen, err, busy);
        checks++;
        if (err !== 1'b1 || wr_a.size() != 18) begin
            errors++;
            $display("FAIL csum_bad: err=%b runs=%0d want 1 18", err, wr_a.size());
        end
    endtask
`endif

    initial begin
        rst       = 1'b1;
        cmd_start = 1'b0;
        cmd_load  = 1'b0;
        cmd_abort = 1'b0;
        ss_gnt    = 1'b0;
        so_ready  = 1'b1;
        si_valid  = 1'b0;
        si_data   = 8'h00;
        xor_mode  = 1'b1;
        foreach (mem[i]) mem[i] = 8'h00;
        clr_env();
        test_reset();
        test_save();
        test_load(8'h7F, 1'b0);
        test_load(8'h7E, 1'b1);
        test_save_stall();
        test_abort();
        test_async_reset();
`ifdef SS_SEQ_CSUM_EN
        test_csum();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
